range_frame_tx: RTL and testbench

Frame transmitter that drives the go/data/finish sample-stream interface consumed by the range-measurement block. Sits between a sample source (write port) and a range finder: it buffers one frame of samples, then plays it out as one `go` cycle with the first sample, one sample per cycle after that, and a closing `finish` cycle. The sequencing guarantees that the downstream block never sees `go` during a run, `finish` outside a run, or `go` adjacent to `finish`.

---
 rtl/range_frame_tx.sv | 156 +++++++++++++++
 tb/tb_range_frame_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/range_frame_tx.sv
// Frame transmitter: buffers one frame of samples, then plays it out as a
// go/data/finish stream for the downstream range-measurement block.
module range_frame_tx #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    output logic             wr_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             done,
    output logic             truncated,
    output logic [7:0]       frame_count
);

    localparam int IW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {FILL, SEND, FIN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    count_q, count_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    len_q, len_d;
    logic [IW-1:0]    idx_inc;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ready_q, ready_d;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             trunc_q, trunc_d;
    logic [7:0]       fcount_q, fcount_d;
    logic             wr_en;

    logic [WIDTH-1:0] frame_buf [DEPTH];

    // NOTE: the sample buffer has no reset; count/len decide which entries are
    // meaningful, so clearing it would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (wr_en)
            frame_buf[count_q[AW-1:0]] <= wr_data;
    end

    assign idx_inc = idx_q + IW'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        len_d    = len_q;
        data_d   = data_q;
        ready_d  = ready_q;
        go_d     = 1'b0;
        finish_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        trunc_d  = trunc_q;
        fcount_d = fcount_q;
        wr_en    = 1'b0;

        unique case (state_q)
            FILL: begin
                if (wr_valid && ready_q) begin
                    wr_en   = 1'b1;
                    count_d = count_q + IW'(1);
                    trunc_d = 1'b0;
                    if (wr_last || count_q == IW'(DEPTH - 1)) begin
                        trunc_d = !wr_last;
                        len_d   = count_q + IW'(1);
                        idx_d   = '0;
                        state_d = SEND;
                        go_d    = 1'b1;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                        // A single-sample frame is still being written, so bypass the buffer.
                        data_d  = (count_q == '0) ? wr_data : frame_buf[0];
                    end
                end
            end
            SEND: begin
                if (idx_q == len_q - IW'(1)) begin
                    state_d  = FIN;
                    finish_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    idx_d  = idx_inc;
                    data_d = frame_buf[idx_inc[AW-1:0]];
                end
            end
            FIN: begin
                state_d  = FILL;
                busy_d   = 1'b0;
                ready_d  = 1'b1;
                count_d  = '0;
                fcount_d = fcount_q + 8'd1;
            end
            default: begin
                state_d = FILL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= FILL;
            count_q  <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            ready_q  <= 1'b1;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            trunc_q  <= 1'b0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            go_q     <= go_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            trunc_q  <= trunc_d;
            fcount_q <= fcount_d;
        end
    end

    assign wr_ready    = ready_q;
    assign data_out    = data_q;
    assign go          = go_q;
    assign finish      = finish_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truncated   = trunc_q;
    assign frame_count = fcount_q;

endmodule

// File: tb/tb_range_frame_tx.sv
// Directed self-checking bench for range_frame_tx with a small downstream
// range-finder model watching the go/data/finish stream.
module tb_range_frame_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic [15:0] data_out;
    logic        go;
    logic        finish;
    logic        busy;
    logic        done;
    logic        truncated;
    logic [7:0]  frame_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] frame_q[$];

    // Downstream model state
    int          cyc = 0;
    int          last_fin = 0;
    bit          have_fin = 1'b0;
    bit          in_run = 1'b0;
    bit          mon_err = 1'b0;
    logic [15:0] mn, mx;
    logic [15:0] last_range = '0;

    range_frame_tx #(.WIDTH(16), .DEPTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .data_out    (data_out),
        .go          (go),
        .finish      (finish),
        .busy        (busy),
        .done        (done),
        .truncated   (truncated),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            in_run   <= 1'b0;
            have_fin <= 1'b0;
        end else if (go) begin
            if (in_run || finish) mon_err <= 1'b1;
            if (have_fin) check("go_spacing", 32'(cyc - last_fin >= 2), 32'd1);
            in_run <= 1'b1;
            mn     <= data_out;
            mx     <= data_out;
        end else if (finish) begin
            if (!in_run) mon_err <= 1'b1;
            in_run     <= 1'b0;
            last_range <= mx - mn;
            last_fin   <= cyc;
            have_fin   <= 1'b1;
        end else if (in_run) begin
            if (data_out < mn) mn <= data_out;
            if (data_out > mx) mx <= data_out;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_frame(input bit use_last);
        for (int i = 0; i < frame_q.size(); i++) begin
            int b;
            wr_valid = 1'b1;
            wr_data  = frame_q[i];
            wr_last  = use_last && (i == frame_q.size() - 1);
            b = 0;
            while (!wr_ready && b < 100) begin
                tick();
                b++;
            end
            if (b >= 100) check("wr_ready_timeout", 32'd0, 32'd1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Called in the go cycle; ends in the cycle where wr_ready rises again.
    task automatic expect_frame(input string tag, input bit stray);
        int n;
        n = frame_q.size();
        check({tag, "_go"}, 32'(go), 32'd1);
        check({tag, "_s0"}, 32'(data_out), 32'(frame_q[0]));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= n; k++) begin
            check({tag, "_ready_low"}, 32'(wr_ready), 32'd0);
            if (stray) begin
                wr_valid = 1'b1;
                wr_data  = 16'hF000 + 16'(k);
            end
            tick();
            if (k < n) begin
                check({tag, "_sample"}, 32'(data_out), 32'(frame_q[k]));
                check({tag, "_go_low"}, 32'(go), 32'd0);
                check({tag, "_fin_low"}, 32'(finish), 32'd0);
            end
        end
        check({tag, "_finish"}, 32'(finish), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_fin_data"}, 32'(data_out), 32'(frame_q[n-1]));
        check({tag, "_fin_ready"}, 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0;
        check({tag, "_ready_back"}, 32'(wr_ready), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_fin_clear"}, 32'(finish), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_go", 32'(go), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_trunc", 32'(truncated), 32'd0);
        check("rst_fcount", 32'(frame_count), 32'd0);
        reset = 1'b0;
        tick();

        // Basic three-sample frame
        frame_q = '{16'd5, 16'd9, 16'd2};
        write_frame(1'b1);
        expect_frame("f3", 1'b0);
        check("f3_range", 32'(last_range), 32'd7);
        check("f3_fcount", 32'(frame_count), 32'd1);

        // Single-sample frame
        frame_q = '{16'h1234};
        write_frame(1'b1);
        expect_frame("f1", 1'b0);
        check("f1_range", 32'(last_range), 32'd0);
        check("f1_fcount", 32'(frame_count), 32'd2);

        // DEPTH-limit truncation
        frame_q.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back(16'(i * 3 + 1));
        write_frame(1'b0);
        check("tr_trunc", 32'(truncated), 32'd1);
        expect_frame("tr", 1'b0);
        check("tr_range", 32'(last_range), 32'd45);
        check("tr_trunc_hold", 32'(truncated), 32'd1);

        // Stray writes during SEND/FIN must be ignored
        wr_valid = 1'b1;
        wr_data  = 16'd10;
        tick();
        check("tr_trunc_clear", 32'(truncated), 32'd0);
        frame_q = '{16'd20, 16'd30};
        write_frame(1'b1);
        frame_q = '{16'd10, 16'd20, 16'd30};
        expect_frame("st", 1'b1);
        check("st_range", 32'(last_range), 32'd20);
        frame_q = '{16'd7};
        write_frame(1'b1);
        expect_frame("st_next", 1'b0);
        check("st_fcount", 32'(frame_count), 32'd5);

        // Reset in the second SEND cycle
        frame_q = '{16'd3, 16'd6, 16'd9};
        write_frame(1'b1);
        check("rs_go", 32'(go), 32'd1);
        tick();
        check("rs_second", 32'(data_out), 32'd6);
        reset = 1'b1;
        #1;
        check("rs_go_clr", 32'(go), 32'd0);
        check("rs_fin_clr", 32'(finish), 32'd0);
        check("rs_busy_clr", 32'(busy), 32'd0);
        check("rs_data_clr", 32'(data_out), 32'd0);
        check("rs_fcount", 32'(frame_count), 32'd0);
        check("rs_ready", 32'(wr_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        frame_q = '{16'd2, 16'd11, 16'd5};
        write_frame(1'b1);
        expect_frame("rs_after", 1'b0);
        check("rs_range", 32'(last_range), 32'd9);
        check("rs_fcount_after", 32'(frame_count), 32'd1);

        // Back-to-back frames
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        frame_q = '{16'd1, 16'd4};
        write_frame(1'b1);
        expect_frame("bb1", 1'b0);
        check("bb1_range", 32'(last_range), 32'd3);
        frame_q = '{16'd8, 16'd3};
        write_frame(1'b1);
        expect_frame("bb2", 1'b0);
        check("bb2_range", 32'(last_range), 32'd5);
        check("bb_fcount", 32'(frame_count), 32'd2);
        tick();
        check("stream_protocol", 32'(mon_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
